// File: rtl/dma_mem_responder.sv
// Memory-side responder for the DMA master data port: word RAM with read/write bursts and ack/error status.
// Optional error injection (err_inject port) is enabled by defining DMA_MEM_ERR_INJECT_EN.
module dma_mem_responder #(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic [31:0] m_rdata,
    input  logic        m_wenable,
    input  logic        m_renable,
    input  logic [11:0] m_wsize,
    input  logic [11:0] m_rsize,
`ifdef DMA_MEM_ERR_INJECT_EN
    input  logic        err_inject,
`endif
    output logic [1:0]  m_err
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [11:0] cnt_q, cnt_d;
    logic        err_flag_q, err_flag_d;
    logic        inj_q, inj_d;
    logic        resp_busy_q;
    logic [1:0]  err_q, err_d;
    logic        rd_ok_q, rd_ok_d;
    logic        mem_we;
    logic [31:0] ram_rd_q;
    logic [31:0] mem_q [MEM_DEPTH];

    logic        inj_cmd;
`ifdef DMA_MEM_ERR_INJECT_EN
    assign inj_cmd = err_inject;
`else
    assign inj_cmd = 1'b0;
`endif

    // Beat address: the command cycle uses the live bus address, later beats the running pointer.
    logic [31:0]   beat_addr, beat_off;
    logic          beat_hit;
    logic [AW-1:0] beat_idx;
    assign beat_addr = (state_q == IDLE) ? m_addr : addr_q;
    assign beat_off  = beat_addr - BASE_ADDR;
    assign beat_hit  = (beat_addr >= BASE_ADDR) && (beat_off < WIN_BYTES);
    assign beat_idx  = beat_off[AW+1:2];

    logic        cmd_any, cmd_rd, cmd_bad, accept;
    logic [11:0] cmd_size;
    assign cmd_any  = m_renable || m_wenable;
    assign cmd_rd   = m_renable;
    assign cmd_size = m_renable ? m_rsize : m_wsize;
    assign cmd_bad  = (m_addr[1:0] != 2'b00) || (cmd_size == 12'd0);
    // The cycle after RESP still shows the response, so no command is taken then.
    assign accept   = (state_q == IDLE) && !resp_busy_q && cmd_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            err_flag_q  <= 1'b0;
            inj_q       <= 1'b0;
            resp_busy_q <= 1'b0;
            err_q       <= 2'b00;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            err_flag_q  <= err_flag_d;
            inj_q       <= inj_d;
            resp_busy_q <= (state_q == RESP);
            err_q       <= err_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_bad)             state_d = RESP;
                    else if (cmd_rd)         state_d = READ;
                    else if (m_wsize == 12'd1) state_d = RESP;
                    else                     state_d = WRITE;
                end
            end
            READ:  if (cnt_q == 12'd1) state_d = IDLE;
            WRITE: if (!m_wenable || cnt_q == 12'd1) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        inj_d      = inj_q;
        err_d      = 2'b00;
        rd_ok_d    = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    inj_d = inj_cmd;
                    if (cmd_bad) begin
                        err_flag_d = 1'b1;
                        cnt_d      = '0;
                    end else if (cmd_rd) begin
                        err_flag_d = 1'b0;
                        addr_d     = m_addr;
                        cnt_d      = m_rsize;
                    end else begin
                        mem_we     = beat_hit && !inj_cmd;
                        err_flag_d = !beat_hit || inj_cmd;
                        addr_d     = m_addr + 32'd4;
                        cnt_d      = m_wsize - 12'd1;
                    end
                end
            end
            READ: begin
                rd_ok_d = beat_hit && !inj_q;
                err_d   = (beat_hit && !inj_q) ? 2'b01 : 2'b11;
                addr_d  = addr_q + 32'd4;
                cnt_d   = cnt_q - 12'd1;
            end
            WRITE: begin
                if (m_wenable) begin
                    mem_we = beat_hit && !inj_q;
                    if (!beat_hit || inj_q) err_flag_d = 1'b1;
                    addr_d = addr_q + 32'd4;
                    cnt_d  = cnt_q - 12'd1;
                end else begin
                    err_flag_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            RESP: begin
                err_d      = err_flag_q ? 2'b11 : 2'b01;
                err_flag_d = 1'b0;
                inj_d      = 1'b0;
                cnt_d      = '0;
            end
            default: ;
        endcase
        // A reset edge landing mid-burst must not commit the beat on the bus.
        if (rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[beat_idx] <= m_wdata;
        ram_rd_q <= mem_q[beat_idx];
    end

    assign m_rdata = rd_ok_q ? ram_rd_q : 32'd0;
    assign m_err   = err_q;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Randomized self-checking bench for dma_mem_responder against a word-array reference model.
module tb_dma_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_wenable, m_renable;
    logic [11:0] m_wsize, m_rsize;
    logic [1:0]  m_err;

    dma_mem_responder #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_wenable (m_wenable),
        .m_renable (m_renable),
        .m_wsize   (m_wsize),
        .m_rsize   (m_rsize),
`ifdef DMA_MEM_ERR_INJECT_EN
        .err_inject(1'b0),
`endif
        .m_err     (m_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_ok  [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read burst (optionally with m_wenable also high, which must be ignored).
    task automatic do_read(input logic [31:0] addr, input int n, input bit also_wr);
        logic [31:0] a;
        bit bad;
        bad = (addr[1:0] != 2'b00) || (n == 0);
        $display("txn read addr=%h n=%0d both=%0d", addr, n, also_wr);
        m_addr = addr; m_rsize = 12'(n); m_renable = 1'b1;
        if (also_wr) begin
            m_wenable = 1'b1; m_wsize = 12'($urandom_range(1, 4)); m_wdata = $urandom;
        end
        step();
        m_renable = 1'b0; m_wenable = 1'b0; m_addr = $urandom;
        if (bad) begin
            step();
            check("rd_reject_err", 32'(m_err), 32'd3);
            check("rd_reject_data", m_rdata, 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                step();
                a = addr + 32'(4 * i);
                if (in_win(a)) begin
                    check("rd_beat_err", 32'(m_err), 32'd1);
                    if (ref_ok[widx(a)]) check("rd_beat_data", m_rdata, ref_mem[widx(a)]);
                end else begin
                    check("rd_oob_err", 32'(m_err), 32'd3);
                    check("rd_oob_data", m_rdata, 32'd0);
                end
            end
        end
        step();
        check("rd_end_err", 32'(m_err), 32'd0);
    endtask

    // Write burst of n words, wenable held for 'taken' beats; dbase!=0 gives sequential data.
    task automatic do_write(input logic [31:0] addr, input int n, input int taken,
                            input logic [31:0] dbase, input bit poke_rd);
        logic [31:0] a, d;
        bit bad, flag;
        bad  = (addr[1:0] != 2'b00) || (n == 0);
        flag = 1'b0;
        $display("txn write addr=%h n=%0d taken=%0d", addr, n, taken);
        if (bad) begin
            m_addr = addr; m_wsize = 12'(n); m_wenable = 1'b1; m_wdata = $urandom;
            step();
            m_wenable = 1'b0;
            step();
            check("wr_reject_err", 32'(m_err), 32'd3);
        end else begin
            m_wsize = 12'(n);
            for (int k = 0; k < taken; k++) begin
                a = addr + 32'(4 * k);
                d = (dbase != 32'd0) ? dbase + 32'(k) : $urandom;
                m_addr = (k == 0) ? addr : $urandom;
                m_wdata = d; m_wenable = 1'b1;
                if (in_win(a)) begin
                    ref_mem[widx(a)] = d; ref_ok[widx(a)] = 1'b1;
                end else begin
                    flag = 1'b1;
                end
                step();
                check("wr_beat_err", 32'(m_err), 32'd0);
            end
            m_wenable = 1'b0; m_wdata = $urandom;
            if (taken < n) begin
                flag = 1'b1;
                step();
                check("wr_abort_gap", 32'(m_err), 32'd0);
            end
            step();
            check("wr_resp", 32'(m_err), flag ? 32'd3 : 32'd1);
        end
        if (poke_rd) begin
            m_addr = BASE; m_rsize = 12'd1; m_renable = 1'b1;
        end
        step();
        m_renable = 1'b0;
        check("wr_end_err", 32'(m_err), 32'd0);
        if (poke_rd) begin
            step();
            check("resp_cycle_rd_ignored", 32'(m_err), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] addr;
        int op, off, n, taken;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_ok[i] = 1'b0; end
        rst = 1'b1; m_addr = '0; m_wdata = '0; m_wenable = 1'b0; m_renable = 1'b0;
        m_wsize = '0; m_rsize = '0;
        step(); step();
        check("reset_rdata", m_rdata, 32'd0);
        check("reset_err", 32'(m_err), 32'd0);
        rst = 1'b0;
        do_read(BASE, 1, 1'b0);

        do_write(BASE, DEPTH, DEPTH, 32'd0, 1'b0);
        do_read(BASE, DEPTH, 1'b0);
        do_write(BASE + 32'h10, 4, 4, 32'hA0, 1'b0);
        do_read(BASE + 32'h10, 4, 1'b0);
        do_read(BASE + 32'(DEPTH * 4) - 32'd4, 3, 1'b0);
        do_read(BASE - 32'd8, 4, 1'b0);
        do_read(32'h0000_0008, 2, 1'b0);
        do_read(BASE + 32'd2, 2, 1'b0);
        do_read(BASE, 0, 1'b0);
        do_write(BASE + 32'd6, 2, 2, 32'd0, 1'b0);
        do_write(BASE, 0, 1, 32'd0, 1'b0);
        do_write(BASE, 8, 5, 32'd0, 1'b0);
        do_read(BASE, 8, 1'b0);
        do_write(BASE + 32'(DEPTH * 4) - 32'd8, 4, 4, 32'd0, 1'b0);
        do_read(BASE + 32'h8, 3, 1'b1);
        do_read(BASE + 32'h8, 3, 1'b0);
        do_write(BASE + 32'h20, 2, 2, 32'd0, 1'b1);

        for (int it = 0; it < 40; it++) begin
            op   = $urandom_range(0, 2);
            off  = int'($urandom_range(0, DEPTH + 8)) - 4;
            addr = BASE + 32'(off * 4);
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            n = $urandom_range(0, 6);
            if (op == 1) begin
                taken = (n == 0) ? 1 : n;
                if (n > 1 && $urandom_range(0, 3) == 0) taken = $urandom_range(1, n - 1);
                do_write(addr, n, taken, 32'd0, 1'b0);
            end else begin
                do_read(addr, n, op == 2);
            end
        end

        do_read(BASE, 4095, 1'b0);

        $display("txn read addr=%h n=6 reset after 2 beats", BASE);
        m_addr = BASE; m_rsize = 12'd6; m_renable = 1'b1;
        step();
        m_renable = 1'b0;
        step();
        check("rst_rd_beat0", m_rdata, ref_mem[0]);
        step();
        check("rst_rd_beat1", m_rdata, ref_mem[1]);
        rst = 1'b1;
        step();
        check("rst_mid_err", 32'(m_err), 32'd0);
        check("rst_mid_data", m_rdata, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_after_err", 32'(m_err), 32'd0);
        end
        do_read(BASE, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
